// File: rtl/axis_sts_pkg.sv
// Shared types and helpers for the S2MM status generator.
// Word indices, FSM encoding, status bit positions, popcount.
package axis_sts_pkg;

  localparam int W0 = 0;
  localparam int W1 = 1;
  localparam int W2 = 2;
  localparam int W3 = 3;
  localparam int W4 = 4;

  typedef enum logic [2:0] {
    ST_W0   = 3'(W0),
    ST_W1   = 3'(W1),
    ST_W2   = 3'(W2),
    ST_W3   = 3'(W3),
    ST_W4   = 3'(W4),
    ST_IDLE = 3'd7
  } sts_state_t;

  localparam logic [3:0] STS_FLAG_DEF = 4'h5;

  localparam int STS_OVF = 0;
  localparam int STS_ZK  = 1;

  function automatic logic [7:0] popcount(input logic [127:0] v);
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < 128; i++) n = n + 8'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/axis_s2mm_sts_gen_if.sv
// AXI-Stream bundle shared by the data, upstream and status ports.
// master drives payload/valid, slave drives ready.
interface axis_s2mm_sts_gen_if #(
  parameter int DW = 128
) ();
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tkeep;
  logic            tvalid;
  logic            tlast;
  logic            tready;

  modport master (
    output tdata, tkeep, tvalid, tlast,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tvalid, tlast,
    output tready
  );
endinterface

// File: rtl/axis_sts_fifo.sv
// Small synchronous FIFO holding pending status records.
// full/empty are registered; more flags a second entry behind head.
module axis_sts_fifo #(
  parameter int W     = 57,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         more
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt, cnt_n;
  logic          wr, rd;

  assign wr   = push & ~full;
  assign rd   = pop & ~empty;
  assign dout = mem[rp];
  assign more = cnt > (AW+1)'(1);

  always_comb begin
    cnt_n = cnt + (AW+1)'(wr) - (AW+1)'(rd);
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      cnt   <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (wr) wp <= wp + AW'(1);
      if (rd) rp <= rp + AW'(1);
      cnt   <= cnt_n;
      full  <= cnt_n == (AW+1)'(DEPTH);
      empty <= cnt_n == '0;
    end
  end
endmodule

// File: rtl/axis_s2mm_sts_gen.sv
// S2MM pass-through that measures each frame and emits a
// 5-word status record per frame on the DMA status stream.
module axis_s2mm_sts_gen
  import axis_sts_pkg::*;
#(
  parameter int         C_S_AXIS_S2MM_TDATA_WIDTH     = 128,
  parameter int         C_S_AXIS_S2MM_STS_TDATA_WIDTH = 32,
  parameter int         C_LEN_WIDTH                   = 23,
  parameter int         C_STS_FIFO_DEPTH              = 4,
  parameter logic [3:0] C_STS_FLAG                    = STS_FLAG_DEF
) (
  input logic                  m_axi_s2mm_aclk,
  input logic                  axi_resetn,
  axis_s2mm_sts_gen_if.slave   aes,
  axis_s2mm_sts_gen_if.master  s_axis_s2mm,
  axis_s2mm_sts_gen_if.master  s_axis_s2mm_sts
);
  localparam int SW = C_S_AXIS_S2MM_STS_TDATA_WIDTH;
  localparam int LW = C_LEN_WIDTH;
  localparam int RW = LW + 34;

  logic          full, empty, more;
  logic          stall, hs, push, pop, sts_hs;
  logic [RW-1:0] rec, head;
  logic [LW-1:0] byte_cnt, byte_nxt;
  logic [LW:0]   byte_sum;
  logic [15:0]   beat_cnt, beat_nxt, seq;
  logic          zk, ovf, zk_nxt, ovf_nxt;
  sts_state_t    state_q, state_d;
  logic [SW-1:0] word_d, word_q;
  logic          vld_q, last_q;

  // Only a frame-ending beat needs a FIFO slot, so only it stalls
  assign stall = aes.tvalid & aes.tlast & full;

  assign s_axis_s2mm.tdata  = aes.tdata;
  assign s_axis_s2mm.tkeep  = aes.tkeep;
  assign s_axis_s2mm.tlast  = aes.tlast;
  assign s_axis_s2mm.tvalid = aes.tvalid & ~stall;
  assign aes.tready         = s_axis_s2mm.tready & ~stall;

  assign hs   = s_axis_s2mm.tvalid & s_axis_s2mm.tready;
  assign push = hs & aes.tlast;

  always_comb begin
    byte_sum = {1'b0, byte_cnt}
             + (LW+1)'(popcount(128'(aes.tkeep)));
    byte_nxt = byte_sum[LW] ? '1 : byte_sum[LW-1:0];
    ovf_nxt  = ovf | byte_sum[LW];
    beat_nxt = (&beat_cnt) ? beat_cnt : beat_cnt + 16'd1;
    zk_nxt   = zk | ~|aes.tkeep;
    rec      = {byte_nxt, beat_nxt, seq, zk_nxt, ovf_nxt};
  end

  always_ff @(posedge m_axi_s2mm_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      byte_cnt <= '0;
      beat_cnt <= '0;
      seq      <= '0;
      zk       <= 1'b0;
      ovf      <= 1'b0;
    end else if (hs) begin
      if (aes.tlast) begin
        byte_cnt <= '0;
        beat_cnt <= '0;
        zk       <= 1'b0;
        ovf      <= 1'b0;
        seq      <= seq + 16'd1;
      end else begin
        byte_cnt <= byte_nxt;
        beat_cnt <= beat_nxt;
        zk       <= zk_nxt;
        ovf      <= ovf_nxt;
      end
    end
  end

  axis_sts_fifo #(
    .W     (RW),
    .DEPTH (C_STS_FIFO_DEPTH)
  ) u_fifo (
    .clk   (m_axi_s2mm_aclk),
    .rst_n (axi_resetn),
    .push  (push),
    .din   (rec),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .more  (more)
  );

  assign sts_hs = vld_q & s_axis_s2mm_sts.tready;

  always_ff @(posedge m_axi_s2mm_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q <= ST_IDLE;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= state_d != ST_IDLE;
      last_q  <= state_d == ST_W4;
      word_q  <= word_d;
    end
  end

  // Head stays put until the W4 pop, so words can be re-read from it
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: if (!empty) state_d = ST_W0;
      ST_W0:   if (sts_hs) state_d = ST_W1;
      ST_W1:   if (sts_hs) state_d = ST_W2;
      ST_W2:   if (sts_hs) state_d = ST_W3;
      ST_W3:   if (sts_hs) state_d = ST_W4;
      ST_W4: begin
        if (sts_hs) begin
          pop     = 1'b1;
          state_d = more ? ST_W0 : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    word_d = '0;
    unique case (state_d)
      ST_W0:   word_d = SW'({C_STS_FLAG, 28'h0});
      ST_W1:   word_d = SW'(head[RW-1 -: LW]);
      ST_W2:   word_d = SW'(head[33:18]);
      ST_W3:   word_d = SW'(head[17:2]);
      ST_W4:   word_d = SW'({head[STS_ZK], head[STS_OVF]});
      default: word_d = '0;
    endcase
  end

  assign s_axis_s2mm_sts.tdata  = word_q;
  assign s_axis_s2mm_sts.tkeep  = '1;
  assign s_axis_s2mm_sts.tvalid = vld_q;
  assign s_axis_s2mm_sts.tlast  = last_q;
endmodule

// File: tb/tb_axis_s2mm_sts_gen.sv
// Bench for axis_s2mm_sts_gen: directed frames plus random traffic
// against a frame-level reference model; a LEN=8 twin checks saturation.
module tb_axis_s2mm_sts_gen;

  localparam int LW_A = 23;
  localparam int LW_B = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axis_s2mm_sts_gen_if #(.DW(128)) aes ();
  axis_s2mm_sts_gen_if #(.DW(128)) dout ();
  axis_s2mm_sts_gen_if #(.DW(32))  sts ();
  axis_s2mm_sts_gen_if #(.DW(128)) aes8 ();
  axis_s2mm_sts_gen_if #(.DW(128)) dout8 ();
  axis_s2mm_sts_gen_if #(.DW(32))  sts8 ();

  assign aes8.tdata   = aes.tdata;
  assign aes8.tkeep   = aes.tkeep;
  assign aes8.tvalid  = aes.tvalid;
  assign aes8.tlast   = aes.tlast;
  assign dout8.tready = dout.tready;
  assign sts8.tready  = sts.tready;

  axis_s2mm_sts_gen #(.C_LEN_WIDTH(LW_A)) dut (
    .m_axi_s2mm_aclk (clk),
    .axi_resetn      (rst_n),
    .aes             (aes),
    .s_axis_s2mm     (dout),
    .s_axis_s2mm_sts (sts)
  );

  axis_s2mm_sts_gen #(.C_LEN_WIDTH(LW_B)) dut8 (
    .m_axi_s2mm_aclk (clk),
    .axi_resetn      (rst_n),
    .aes             (aes8),
    .s_axis_s2mm     (dout8),
    .s_axis_s2mm_sts (sts8)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          bytes;
    int          beats;
    logic [15:0] seq;
    bit          zk;
  } rec_t;

  rec_t        q_a[$];
  rec_t        q_b[$];
  int          idx_a, idx_b, occ;
  int          acc_bytes, acc_beats;
  bit          acc_zk;
  logic [15:0] seq_m;
  logic [31:0] w_a [5];
  logic [31:0] w_b [5];
  logic [15:0] seen3[$];
  logic [15:0] kq[$];
  int          drdy_mode = 0;
  int          sts_mode = 0;

  function automatic logic [31:0] exp_word(rec_t r, int i, int lw);
    longint mx;
    longint b;
    bit     ov;
    int     bt;
    mx = (longint'(1) << lw) - 1;
    ov = longint'(r.bytes) > mx;
    b  = ov ? mx : longint'(r.bytes);
    bt = (r.beats > 65535) ? 65535 : r.beats;
    case (i)
      0:       return 32'h5000_0000;
      1:       return 32'(b);
      2:       return 32'(bt);
      3:       return {16'h0, r.seq};
      default: return {30'h0, r.zk, ov};
    endcase
  endfunction

  // Reference model: sampled mid-cycle, it predicts the coming edge
  always @(negedge clk) begin
    if (!rst_n) begin
      q_a.delete();
      q_b.delete();
      idx_a = 0;
      idx_b = 0;
      occ = 0;
      acc_bytes = 0;
      acc_beats = 0;
      acc_zk = 0;
      seq_m = '0;
    end else begin : mon
      bit   stall_e;
      bit   hs_e;
      rec_t r;
      stall_e = aes.tvalid && aes.tlast && (occ == 4);
      hs_e = aes.tvalid && !stall_e && dout.tready;
      check("s_tvalid", dout.tvalid, aes.tvalid && !stall_e);
      check("a_tready", aes.tready, dout.tready && !stall_e);
      check("s_tvalid8", dout8.tvalid, aes.tvalid && !stall_e);
      check("a_tready8", aes8.tready, dout.tready && !stall_e);
      if (aes.tvalid) begin
        check("s_tdata", dout.tdata, aes.tdata);
        check("s_tkeep", dout.tkeep, aes.tkeep);
        check("s_tlast", dout.tlast, aes.tlast);
      end
      if (hs_e) begin
        acc_bytes += $countones(aes.tkeep);
        acc_beats++;
        acc_zk |= (aes.tkeep == 16'h0);
        if (aes.tlast) begin
          r.bytes = acc_bytes;
          r.beats = acc_beats;
          r.seq = seq_m;
          r.zk = acc_zk;
          q_a.push_back(r);
          q_b.push_back(r);
          seq_m++;
          occ++;
          acc_bytes = 0;
          acc_beats = 0;
          acc_zk = 0;
        end
      end
      if (sts.tvalid && sts.tready) begin
        if (q_a.size() == 0) check("sts_extra", sts.tvalid, 0);
        else begin
          check($sformatf("sts_w%0d", idx_a), sts.tdata,
                exp_word(q_a[0], idx_a, LW_A));
          check("sts_tlast", sts.tlast, idx_a == 4);
          check("sts_tkeep", sts.tkeep, 4'hF);
          w_a[idx_a] = sts.tdata;
          if (idx_a == 3) seen3.push_back(sts.tdata[15:0]);
          idx_a++;
          if (idx_a == 5) begin
            idx_a = 0;
            void'(q_a.pop_front());
            occ--;
          end
        end
      end
      if (sts8.tvalid && sts8.tready) begin
        if (q_b.size() == 0) check("sts8_extra", sts8.tvalid, 0);
        else begin
          check($sformatf("sts8_w%0d", idx_b), sts8.tdata,
                exp_word(q_b[0], idx_b, LW_B));
          check("sts8_tlast", sts8.tlast, idx_b == 4);
          w_b[idx_b] = sts8.tdata;
          idx_b++;
          if (idx_b == 5) begin
            idx_b = 0;
            void'(q_b.pop_front());
          end
        end
      end
    end
  end

  initial begin
    dout.tready = 1'b1;
    sts.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      dout.tready = (drdy_mode != 0) ? 1'($urandom_range(1, 0)) : 1'b1;
      case (sts_mode)
        0:       sts.tready = 1'b1;
        1:       sts.tready = 1'b0;
        default: sts.tready = 1'($urandom_range(1, 0));
      endcase
    end
  end

  task automatic start_beat(logic [15:0] keep, logic last);
    aes.tdata = {$urandom(), $urandom(), $urandom(), $urandom()};
    aes.tkeep = keep;
    aes.tlast = last;
    aes.tvalid = 1'b1;
  endtask

  task automatic wait_hs(output bit ok);
    bit hs;
    ok = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      hs = dout.tvalid && dout.tready;
      @(posedge clk);
      #1;
      if (hs) begin
        ok = 1;
        break;
      end
    end
    aes.tvalid = 1'b0;
    aes.tlast = 1'b0;
  endtask

  task automatic send_kq(int gap_max);
    bit ok;
    for (int i = 0; i < kq.size(); i++) begin
      repeat ($urandom_range(gap_max, 0)) begin
        @(posedge clk);
        #1;
      end
      start_beat(kq[i], i == kq.size() - 1);
      wait_hs(ok);
      check("beat_hs", ok, 1);
    end
  endtask

  task automatic send_full(int n);
    kq.delete();
    repeat (n) kq.push_back(16'hFFFF);
    send_kq(0);
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      if (q_a.size() == 0 && q_b.size() == 0 &&
          idx_a == 0 && idx_b == 0) begin
        done = 1;
        break;
      end
    end
    check("drain", done, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    aes.tvalid = 1'b0;
    aes.tlast = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bit ok;
    bit found;
    aes.tdata = '0;
    aes.tkeep = 16'hFFFF;
    aes.tvalid = 1'b1;
    aes.tlast = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sts_tvalid", sts.tvalid, 0);
    check("rst_sts_tlast", sts.tlast, 0);
    check("rst_sts_tdata", sts.tdata, 0);
    check("rst_sts8_tvalid", sts8.tvalid, 0);
    check("rst_s_tvalid", dout.tvalid, 1);
    check("rst_a_tready", aes.tready, 1);
    aes.tvalid = 1'b0;
    aes.tlast = 1'b0;
    rst_n = 1'b1;

    // 4-beat full frame
    send_full(4);
    drain();
    check("t1_w0", w_a[0], 32'h5000_0000);
    check("t1_w1", w_a[1], 32'h40);
    check("t1_w2", w_a[2], 32'h4);
    check("t1_w3", w_a[3], 32'h0);
    check("t1_w4", w_a[4], 32'h0);

    // partial last beat
    do_reset();
    kq.delete();
    kq.push_back(16'hFFFF);
    kq.push_back(16'hFFFF);
    kq.push_back(16'h00FF);
    send_kq(0);
    drain();
    check("t2_w1", w_a[1], 32'h28);
    check("t2_w2", w_a[2], 32'h3);
    check("t2_w3", w_a[3], 32'h0);

    // FIFO full stall with status stream blocked
    do_reset();
    sts_mode = 1;
    seen3.delete();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      start_beat(16'hFFFF, 1'b1);
      wait_hs(ok);
      check("t3_push", ok, 1);
    end
    start_beat(16'hFFFF, 1'b1);
    @(negedge clk);
    check("t3_a_tready", aes.tready, 0);
    check("t3_s_tvalid", dout.tvalid, 0);
    repeat (3) @(posedge clk);
    #1;
    sts_mode = 0;
    wait_hs(ok);
    check("t3_fifth", ok, 1);
    drain();
    check("t3_nseq", seen3.size(), 5);
    for (int i = 0; i < 5 && i < seen3.size(); i++)
      check($sformatf("t3_seq%0d", i), seen3[i], 16'(i));

    // byte-count saturation on the LEN=8 twin
    do_reset();
    send_full(17);
    drain();
    check("t4_w1_len8", w_b[1], 32'hFF);
    check("t4_w4_len8", w_b[4], 32'h1);
    check("t4_w1", w_a[1], 32'h110);
    check("t4_w2", w_a[2], 32'h11);
    check("t4_w4", w_a[4], 32'h0);

    // zero-keep beat inside a frame
    do_reset();
    kq.delete();
    kq.push_back(16'hFFFF);
    kq.push_back(16'h0000);
    kq.push_back(16'hFFFF);
    send_kq(0);
    drain();
    check("t5_w1", w_a[1], 32'h20);
    check("t5_w2", w_a[2], 32'h3);
    check("t5_w4", w_a[4], 32'h2);

    // reset in the middle of a status record
    do_reset();
    kq.delete();
    kq.push_back(16'hFFFF);
    kq.push_back(16'hFFFF);
    send_kq(0);
    found = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      #1;
      if (idx_a == 2) begin
        found = 1;
        break;
      end
    end
    check("t6_w1_seen", found, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_tvalid", sts.tvalid, 0);
    check("t6_rst_tvalid8", sts8.tvalid, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    kq.delete();
    kq.push_back(16'hFFFF);
    kq.push_back(16'h00FF);
    send_kq(0);
    drain();
    check("t6_w1", w_a[1], 32'h18);
    check("t6_w2", w_a[2], 32'h2);
    check("t6_w3", w_a[3], 32'h0);

    // random traffic with random backpressure on both outputs
    sts_mode = 2;
    drdy_mode = 1;
    repeat (40) begin
      int nb;
      int sel;
      nb = ($urandom_range(3, 0) == 0) ? $urandom_range(20, 14)
                                        : $urandom_range(4, 1);
      kq.delete();
      repeat (nb) begin
        sel = $urandom_range(3, 0);
        if (sel == 0) kq.push_back(16'h0000);
        else if (sel == 1) kq.push_back(16'hFFFF);
        else kq.push_back(16'($urandom()));
      end
      send_kq(2);
    end
    sts_mode = 0;
    drdy_mode = 0;
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
